// File: rtl/gsu_operand_select_p_pkg.sv
// gsu_pkg: shared widths, FSM state type and reset constants for the operand selector
package gsu_pkg;
    localparam int GSU_DATA_W    = 16;
    localparam int GSU_NUM_REGS  = 16;
    localparam int GSU_NUM_PORTS = 2;

    typedef enum logic {IDLE, PREFIXED} state_t;

    localparam state_t RST_STATE = IDLE;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gsu_operand_select_p_if.sv
// gsu_operand_select_p_if: register-file, prefix-control and operand-bus bundle of the selector
interface gsu_operand_select_p_if #(
    parameter int DATA_W    = gsu_pkg::GSU_DATA_W,
    parameter int NUM_REGS  = gsu_pkg::GSU_NUM_REGS,
    parameter int NUM_PORTS = gsu_pkg::GSU_NUM_PORTS
);
    localparam int SEL_W = gsu_pkg::sel_w(NUM_REGS);

    logic [NUM_REGS*DATA_W-1:0]  regs_flat;
    logic [NUM_PORTS*SEL_W-1:0]  port_sel;
    logic [NUM_PORTS-1:0]        port_use_sreg;
    logic                        from_valid;
    logic                        to_valid;
    logic                        with_valid;
    logic [SEL_W-1:0]            prefix_reg;
    logic                        instr_done;
    logic                        stall;
    logic                        wr_en;
    logic [SEL_W-1:0]            wr_addr;
    logic [DATA_W-1:0]           wr_data;
    logic [NUM_PORTS*DATA_W-1:0] port_bus;
    logic [SEL_W-1:0]            sreg;
    logic [SEL_W-1:0]            dreg;
    logic                        b_flag;

    modport master (
        output regs_flat, port_sel, port_use_sreg, from_valid, to_valid, with_valid,
               prefix_reg, instr_done, stall, wr_en, wr_addr, wr_data,
        input  port_bus, sreg, dreg, b_flag
    );

    modport slave (
        input  regs_flat, port_sel, port_use_sreg, from_valid, to_valid, with_valid,
               prefix_reg, instr_done, stall, wr_en, wr_addr, wr_data,
        output port_bus, sreg, dreg, b_flag
    );
endinterface

// File: rtl/gsu_operand_select_p_reg_read_port.sv
// gsu_reg_read_port: one combinational register-file read mux; write-through bypass under OPSEL_FWD_EN
module gsu_reg_read_port #(
    parameter int DATA_W   = gsu_pkg::GSU_DATA_W,
    parameter int NUM_REGS = gsu_pkg::GSU_NUM_REGS,
    parameter int SEL_W    = gsu_pkg::sel_w(NUM_REGS)
) (
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat_i,
    input  logic [SEL_W-1:0]           idx_i,
    input  logic                       wr_en_i,
    input  logic [SEL_W-1:0]           wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic [DATA_W-1:0]          data_o
);
    logic hit;

    // Decode the index; anything past the last register reads as zero and never forwards
    always_comb begin
        data_o = '0;
        hit    = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (idx_i == SEL_W'(r)) begin
                data_o = regs_flat_i[r*DATA_W +: DATA_W];
                hit    = 1'b1;
            end
        end
`ifdef OPSEL_FWD_EN
        if (hit && wr_en_i && wr_addr_i == idx_i) data_o = wr_data_i;
`endif
    end

`ifndef OPSEL_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{wr_en_i, wr_addr_i, wr_data_i, hit};
`endif
endmodule

// File: rtl/gsu_operand_select_p.sv
// gsu_operand_select_p: FROM/TO/WITH prefix state and registered operand buses (optional OPSEL_FWD_EN bypass)
module gsu_operand_select_p #(
    parameter int DATA_W    = gsu_pkg::GSU_DATA_W,
    parameter int NUM_REGS  = gsu_pkg::GSU_NUM_REGS,
    parameter int NUM_PORTS = gsu_pkg::GSU_NUM_PORTS
) (
    input logic                   clk,
    input logic                   rst_n,
    gsu_operand_select_p_if.slave bus
);
    import gsu_pkg::*;

    localparam int SEL_W = sel_w(NUM_REGS);

    state_t                      state_q, state_d;
    logic [SEL_W-1:0]            sreg_q, sreg_d, dreg_q, dreg_d;
    logic                        b_q, b_d;
    logic [NUM_PORTS*DATA_W-1:0] bus_q, bus_d, rd_flat;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        gsu_reg_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_rd (
            .regs_flat_i (bus.regs_flat),
            .idx_i       (bus.port_use_sreg[p] ? sreg_q : bus.port_sel[p*SEL_W +: SEL_W]),
            .wr_en_i     (bus.wr_en),
            .wr_addr_i   (bus.wr_addr),
            .wr_data_i   (bus.wr_data),
            .data_o      (rd_flat[p*DATA_W +: DATA_W])
        );
    end

    // Prefix FSM: with > to > from > instr_done; a stall drops this cycle's strobes
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        dreg_d  = dreg_q;
        b_d     = b_q;
        bus_d   = bus.stall ? bus_q : rd_flat;
        if (!bus.stall) begin
            if (bus.with_valid) begin
                sreg_d  = bus.prefix_reg;
                dreg_d  = bus.prefix_reg;
                b_d     = 1'b1;
                state_d = PREFIXED;
            end else if (bus.to_valid) begin
                dreg_d  = bus.prefix_reg;
                b_d     = 1'b0;
                state_d = PREFIXED;
            end else if (bus.from_valid) begin
                sreg_d  = bus.prefix_reg;
                b_d     = 1'b0;
                state_d = PREFIXED;
            end else if (bus.instr_done) begin
                sreg_d  = '0;
                dreg_d  = '0;
                b_d     = 1'b0;
                state_d = IDLE;
            end
        end
    end

    // All state advances on the falling clock edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            sreg_q  <= '0;
            dreg_q  <= '0;
            b_q     <= 1'b0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            dreg_q  <= dreg_d;
            b_q     <= b_d;
            bus_q   <= bus_d;
        end
    end

    assign bus.port_bus = bus_q;
    assign bus.sreg     = sreg_q;
    assign bus.dreg     = dreg_q;
    assign bus.b_flag   = b_q;
endmodule
